// File: rtl/axi_regfile_pkg.sv
// Shared types and helpers for the multimode AXI4-Lite register file.
package axi_regfile_pkg;

   localparam int unsigned DW = 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axi_resp_t;

   // Word index from a byte address; bits at or above aw are never decoded.
   function automatic logic [31:0] widx(
      input logic [31:0] addr,
      input int unsigned aw
   );
      logic [31:0] m;
      m = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
      return (addr & m) >> 2;
   endfunction

   function automatic logic [DW-1:0] strb_mask(
      input logic [DW/8-1:0] strb
   );
      logic [DW-1:0] m;
      for (int unsigned b = 0; b < DW/8; b++) begin
         m[b*8 +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/axi_lite_wr_hold.sv
// One-deep holding register for an AXI4-Lite AW or W channel.
module axi_lite_wr_hold #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         ready_o,
   input  logic         clr_i,
   output logic         held_o,
   output logic [W-1:0] data_o
);

   logic         held_q, held_d;
   logic [W-1:0] data_q, data_d;

   assign ready_o = !held_q && !rst_i;
   assign held_o  = held_q;
   assign data_o  = data_q;

   always_comb begin
      held_d = held_q;
      data_d = data_q;
      if (clr_i) begin
         held_d = 1'b0;
      end
      if (valid_i && ready_o) begin
         held_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         held_q <= 1'b0;
         data_q <= '0;
      end else begin
         held_q <= held_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/axi_regfile_multimode.sv
// AXI4-Lite register file with per-register RW / RO / W1C / pulse modes.
module axi_regfile_multimode
   import axi_regfile_pkg::*;
#(
   parameter int unsigned              NREGS      = 16,
   parameter int unsigned              ADDR_WIDTH = 10,
   parameter logic [NREGS-1:0]         RO_MASK    = 'h3,
   parameter logic [NREGS-1:0]         W1C_MASK   = 'h0,
   parameter logic [NREGS-1:0]         PULSE_MASK = 'h0,
   parameter logic [NREGS-1:0][DW-1:0] RST_VAL    = '0
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]       S_AXI_AWADDR,
   input  logic [2:0]                  S_AXI_AWPROT,
   input  logic                        S_AXI_AWVALID,
   output logic                        S_AXI_AWREADY,
   input  logic [DW-1:0]               S_AXI_WDATA,
   input  logic [DW/8-1:0]             S_AXI_WSTRB,
   input  logic                        S_AXI_WVALID,
   output logic                        S_AXI_WREADY,
   output logic [1:0]                  S_AXI_BRESP,
   output logic                        S_AXI_BVALID,
   input  logic                        S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]       S_AXI_ARADDR,
   input  logic [2:0]                  S_AXI_ARPROT,
   input  logic                        S_AXI_ARVALID,
   output logic                        S_AXI_ARREADY,
   output logic [DW-1:0]               S_AXI_RDATA,
   output logic [1:0]                  S_AXI_RRESP,
   output logic                        S_AXI_RVALID,
   input  logic                        S_AXI_RREADY,
   output logic [NREGS-1:0][DW-1:0]    slv_reg,
   input  logic [NREGS-1:0][DW-1:0]    slv_read,
   input  logic [NREGS-1:0][DW-1:0]    w1c_set,
   output logic [NREGS-1:0]            wr_pulse,
   output logic [NREGS-1:0]            rd_pulse
);

   logic                  clk, rst;
   logic                  aw_held, w_held;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [DW+DW/8-1:0]    w_bus;
   logic                  commit;
   logic [31:0]           wsel, rsel;
   logic                  w_inrng, r_inrng;
   logic [DW-1:0]         wdata, wmask;
   logic                  ar_acc;

   logic                  bvalid_q, bvalid_d;
   axi_resp_t             bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   axi_resp_t             rresp_q, rresp_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic [NREGS-1:0]      wr_pulse_q, wr_pulse_d;
   logic [NREGS-1:0]      rd_pulse_q, rd_pulse_d;

   logic                  unused_ok;

   assign clk = S_AXI_ACLK;
   assign rst = S_AXI_ARESET;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        slv_read, w1c_set};

   axi_lite_wr_hold #(.W(ADDR_WIDTH)) u_aw_hold (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (S_AXI_AWVALID),
      .data_i  (S_AXI_AWADDR),
      .ready_o (S_AXI_AWREADY),
      .clr_i   (commit),
      .held_o  (aw_held),
      .data_o  (aw_addr)
   );

   axi_lite_wr_hold #(.W(DW+DW/8)) u_w_hold (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (S_AXI_WVALID),
      .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
      .ready_o (S_AXI_WREADY),
      .clr_i   (commit),
      .held_o  (w_held),
      .data_o  (w_bus)
   );

   assign commit  = aw_held && w_held &&
                    (!bvalid_q || S_AXI_BREADY);
   assign wsel    = widx(32'(aw_addr), ADDR_WIDTH);
   assign w_inrng = wsel < NREGS;
   assign wdata   = w_bus[DW-1:0];
   assign wmask   = strb_mask(w_bus[DW +: DW/8]);

   assign S_AXI_ARREADY = (!rvalid_q || S_AXI_RREADY) && !rst;
   assign ar_acc  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign rsel    = widx(32'(S_AXI_ARADDR), ADDR_WIDTH);
   assign r_inrng = rsel < NREGS;

   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
         assign slv_reg[i] = '0;
      end else begin : g_rw
         logic [DW-1:0] reg_q, reg_d;

         // Hardware set is applied after the software clear so set wins.
         always_comb begin
            reg_d = reg_q;
            if (commit && wsel == i) begin
               if (W1C_MASK[i]) begin
                  reg_d = reg_q & ~(wdata & wmask);
               end else begin
                  reg_d = (reg_q & ~wmask) | (wdata & wmask);
               end
            end
            if (W1C_MASK[i]) begin
               reg_d = reg_d | w1c_set[i];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               reg_q <= RST_VAL[i];
            end else begin
               reg_q <= reg_d;
            end
         end

         assign slv_reg[i] = reg_q;
      end
   end

   always_comb begin
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = w_inrng ? OKAY : SLVERR;
      end else if (S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
      for (int unsigned i = 0; i < NREGS; i++) begin
         wr_pulse_d[i] = commit && (wsel == i) && PULSE_MASK[i];
      end
   end

   // Read data comes from the pre-commit register state.
   always_comb begin
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rd_pulse_d = '0;
      if (ar_acc) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = r_inrng ? OKAY : SLVERR;
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (rsel == i) begin
               rdata_d       = RO_MASK[i] ? slv_read[i] : slv_reg[i];
               rd_pulse_d[i] = 1'b1;
            end
         end
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= OKAY;
         rdata_q    <= '0;
         wr_pulse_q <= '0;
         rd_pulse_q <= '0;
      end else begin
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         wr_pulse_q <= wr_pulse_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RDATA  = rdata_q;
   assign wr_pulse     = wr_pulse_q;
   assign rd_pulse     = rd_pulse_q;

endmodule
